cnnip_seq_ctrlr: RTL and testbench
==================================

// Module: cnnip_seq_ctrlr
// PURPOSE
//  Parametrised CNN IP sequencer. It loads an IMG_DIM x IMG_DIM input map and
//  NK KxK kernels into the internal input and weight memories, then steps the
//  convolution PE over every output pixel of every kernel. Each PE result is
//  written to the feature memory. Sits between the config registers/AXI stream
//  side and the PE datapath.
// PARAMETERS
//  DATA_W   8   input/weight word width
//  ACC_W    20  PE result / feature word width
//  IMG_DIM  16  input map height = width (2..255)
//  MAX_K    5   largest kernel size accepted
//  MAX_NK   8   largest kernel count accepted
//  derived: XA_W=clog2(IMG_DIM^2), WA_W=clog2(MAX_NK*MAX_K^2), FA_W=clog2(MAX_NK*IMG_DIM^2)
// PORTS
//  clk_a            in   1       single clock
//  arstz_aq         in   1       async active-low reset
//  cmd_start        in   1       start request, sampled in IDLE only
//  cmd_abort        in   1       abort request, any state
//  mode_kernel_size in   8       K
//  mode_kernel_nums in   8       NK
//  mode_stride      in   2       S
//  mode_padding     in   1       1: pad P=(K-1)/2 zeros per side; 0: P=0
//  x_valid/x_data   in   1/DATA_W  input-map stream, raster order
//  x_ready          out  1       high only in LOAD_X
//  w_valid/w_data   in   1/DATA_W  weight stream, kernel-major then raster
//  w_ready          out  1       high only in LOAD_W
//  xmem_we/xmem_addr/xmem_wdata  out 1/XA_W/DATA_W  input-memory write port
//  wmem_we/wmem_addr/wmem_wdata  out 1/WA_W/DATA_W  weight-memory write port
//  pe_start         out  1       one-cycle pulse: compute the pixel at pe_kidx/pe_oy/pe_ox
//  pe_kidx/pe_oy/pe_ox out 8/8/8 current kernel and output coordinate
//  pe_done/pe_result in  1/ACC_W PE result valid (single-cycle)
//  fmem_we/fmem_addr/fmem_wdata  out 1/FA_W/ACC_W  feature-memory write port
//  busy             out  1       state != IDLE
//  cmd_done         out  1       one-cycle pulse in DONE
//  cmd_err          out  1       valid with cmd_done; config was illegal
// BEHAVIOUR
//  Reset: state IDLE; all outputs and counters 0. Async assert, sync use on the next edge.
//  States: IDLE, LOAD_X, LOAD_W, CONV, DONE.
//  IDLE: on cmd_start, latch K/NK/S/padding into shadow regs.
//    - Config legal: go to LOAD_X.
//    - Config illegal: go to DONE with err flag set.
//  Illegal config: K==0, K>MAX_K, NK==0, NK>MAX_NK, S==0, or K>IMG_DIM+2P.
//  Mode inputs are ignored after the latch. cmd_start outside IDLE is ignored.
//  LOAD_X: a beat is a cycle with x_valid&&x_ready.
//    - Each beat drives xmem_we=1, xmem_addr=beat index, xmem_wdata=x_data in the same cycle (combinational).
//    - Gaps in x_valid are tolerated.
//    - After beat IMG_DIM^2-1, go to LOAD_W.
//  LOAD_W: same rules on the w_* stream and wmem_*; NK*K*K beats, then go to CONV.
//  Output dimension O=(IMG_DIM+2P-K)/S+1, integer floor, computed from the shadow regs.
//  CONV: iteration order is ox fastest, then oy, then kidx.
//    - The controller pulses pe_start for one cycle, then waits. Coordinates are held stable until pe_done.
//    - On pe_done: fmem_we=1, fmem_wdata=pe_result, fmem_addr=kidx*O*O+oy*O+ox, all in that cycle.
//    - The next pe_start follows on the next cycle, so one output costs at least 2 cycles.
//    - pe_done outside the wait phase is ignored.
//    - After the result for (NK-1,O-1,O-1) is written, go to DONE.
//  DONE: lasts 1 cycle. cmd_done=1, cmd_err=err flag. Then go to IDLE and clear the err flag.
//  cmd_abort: from any non-IDLE state, go to IDLE next cycle.
//    - No cmd_done pulse. Counters clear.
//    - Memory writes stop that cycle.
//    - Abort wins over a simultaneous final beat or pe_done.
//  Counter wrap: none. All counters clear on entering each state.
// TESTING
//  1. K=3,NK=2,S=1,P=0, streams always valid -> 256 xmem writes (last addr 255); 18 wmem writes; 392 fmem writes (last addr 391); one cmd_done with cmd_err=0.
//  2. K=3,S=2,padding=1,NK=1 -> O=8; 64 pe_start pulses; final pe_ox=pe_oy=7; fmem addr 0..63.
//  3. x_valid/w_valid toggling randomly, pe_done delayed 1..5 cycles -> addresses contiguous, no duplicate or missing writes.
//  4. K=0 (or S=0, or NK=9) -> DONE exactly 2 cycles after cmd_start; cmd_err=1; no mem writes.
//  5. cmd_abort on weight beat 5 of LOAD_W -> IDLE next cycle, no cmd_done; a following cmd_start runs cleanly from address 0.
//  6. arstz_aq low mid-CONV -> all outputs 0 immediately; IDLE after release; pe_done while in IDLE causes no fmem write.

Source files
------------

// File: rtl/cnnip_seq_ctrlr.sv
// CNN IP sequencer: streams the input map and kernels into local memories, then
// walks the PE over every output pixel of every kernel and stores each result.
//
// state  | meaning
// IDLE   | waiting for cmd_start; config latched and checked on start
// LOAD_X | accepting IMG_DIM^2 input-map beats into xmem
// LOAD_W | accepting NK*K*K weight beats into wmem
// CONV   | pe_start pulse, then wait for pe_done and store to fmem
// DONE   | single-cycle cmd_done / cmd_err report
module cnnip_seq_ctrlr #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int IMG_DIM = 16,
  parameter int MAX_K   = 5,
  parameter int MAX_NK  = 8,
  parameter int XA_W    = $clog2(IMG_DIM*IMG_DIM),
  parameter int WA_W    = $clog2(MAX_NK*MAX_K*MAX_K),
  parameter int FA_W    = $clog2(MAX_NK*IMG_DIM*IMG_DIM)
) (
  input  logic              clk_a,
  input  logic              arstz_aq,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [7:0]        mode_kernel_size,
  input  logic [7:0]        mode_kernel_nums,
  input  logic [1:0]        mode_stride,
  input  logic              mode_padding,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_data,
  output logic              x_ready,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  output logic              xmem_we,
  output logic [XA_W-1:0]   xmem_addr,
  output logic [DATA_W-1:0] xmem_wdata,
  output logic              wmem_we,
  output logic [WA_W-1:0]   wmem_addr,
  output logic [DATA_W-1:0] wmem_wdata,
  output logic              pe_start,
  output logic [7:0]        pe_kidx,
  output logic [7:0]        pe_oy,
  output logic [7:0]        pe_ox,
  input  logic              pe_done,
  input  logic [ACC_W-1:0]  pe_result,
  output logic              fmem_we,
  output logic [FA_W-1:0]   fmem_addr,
  output logic [ACC_W-1:0]  fmem_wdata,
  output logic              busy,
  output logic              cmd_done,
  output logic              cmd_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_X = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_CONV   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CW = (XA_W > WA_W) ? XA_W : WA_W;
  localparam logic [CW-1:0] X_LAST = CW'(IMG_DIM*IMG_DIM-1);

  logic [2:0]      state;
  logic [7:0]      k_q, nk_q;
  logic [1:0]      s_q;
  logic            pad_q, err_q;
  logic [CW-1:0]   cnt;
  logic            conv_wait;
  logic [FA_W-1:0] f_cnt;
  logic [7:0]      kidx, oy, ox;

  logic [9:0]  pad_in, pad_amt, o_last;
  logic [1:0]  s_div;
  logic [15:0] w_last;
  logic        cfg_bad;

  assign pad_in  = mode_padding ? 10'((mode_kernel_size - 8'd1) >> 1) : 10'd0;
  assign cfg_bad = (mode_kernel_size == 8'd0) || (mode_kernel_size > 8'(MAX_K)) ||
                   (mode_kernel_nums == 8'd0) || (mode_kernel_nums > 8'(MAX_NK)) ||
                   (mode_stride == 2'd0) ||
                   (10'(mode_kernel_size) > 10'(IMG_DIM) + (pad_in << 1));

  // Output extent is derived from the shadow copy so mode inputs may change mid-run.
  assign pad_amt = pad_q ? 10'((k_q - 8'd1) >> 1) : 10'd0;
  assign s_div   = (s_q == 2'd0) ? 2'd1 : s_q;
  assign o_last  = (10'(IMG_DIM) + (pad_amt << 1) - 10'(k_q)) / 10'(s_div);
  assign w_last  = 16'(nk_q) * 16'(k_q) * 16'(k_q) - 16'd1;

  assign x_ready    = (state == S_LOAD_X);
  assign w_ready    = (state == S_LOAD_W);
  assign xmem_we    = x_valid && x_ready && !cmd_abort;
  assign xmem_addr  = cnt[XA_W-1:0];
  assign xmem_wdata = xmem_we ? x_data : '0;
  assign wmem_we    = w_valid && w_ready && !cmd_abort;
  assign wmem_addr  = cnt[WA_W-1:0];
  assign wmem_wdata = wmem_we ? w_data : '0;

  assign pe_start   = (state == S_CONV) && !conv_wait;
  assign pe_kidx    = kidx;
  assign pe_oy      = oy;
  assign pe_ox      = ox;
  assign fmem_we    = (state == S_CONV) && conv_wait && pe_done && !cmd_abort;
  assign fmem_addr  = f_cnt;
  assign fmem_wdata = fmem_we ? pe_result : '0;

  assign busy     = (state != S_IDLE);
  assign cmd_done = (state == S_DONE) && !cmd_abort;
  assign cmd_err  = cmd_done && err_q;

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state     <= S_IDLE;
      k_q       <= '0;
      nk_q      <= '0;
      s_q       <= '0;
      pad_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      conv_wait <= 1'b0;
      f_cnt     <= '0;
      kidx      <= '0;
      oy        <= '0;
      ox        <= '0;
    end else if (cmd_abort && (state != S_IDLE)) begin
      state     <= S_IDLE;
      err_q     <= 1'b0;
      cnt       <= '0;
      conv_wait <= 1'b0;
      f_cnt     <= '0;
      kidx      <= '0;
      oy        <= '0;
      ox        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            k_q   <= mode_kernel_size;
            nk_q  <= mode_kernel_nums;
            s_q   <= mode_stride;
            pad_q <= mode_padding;
            err_q <= cfg_bad;
            cnt   <= '0;
            state <= cfg_bad ? S_DONE : S_LOAD_X;
          end
        end
        S_LOAD_X: begin
          if (x_valid) begin
            if (cnt == X_LAST) begin
              cnt   <= '0;
              state <= S_LOAD_W;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (w_valid) begin
            if (16'(cnt) == w_last) begin
              cnt       <= '0;
              conv_wait <= 1'b0;
              f_cnt     <= '0;
              kidx      <= '0;
              oy        <= '0;
              ox        <= '0;
              state     <= S_CONV;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_CONV: begin
          if (!conv_wait) begin
            conv_wait <= 1'b1;
          end else if (pe_done) begin
            // fmem address advances in the same raster order as the coordinates.
            conv_wait <= 1'b0;
            f_cnt     <= f_cnt + 1'b1;
            if (10'(ox) == o_last) begin
              ox <= '0;
              if (10'(oy) == o_last) begin
                oy <= '0;
                if (kidx == nk_q - 8'd1) begin
                  kidx  <= '0;
                  f_cnt <= '0;
                  state <= S_DONE;
                end else begin
                  kidx <= kidx + 8'd1;
                end
              end else begin
                oy <= oy + 8'd1;
              end
            end else begin
              ox <= ox + 8'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnnip_seq_ctrlr.sv
// Scoreboard bench for cnnip_seq_ctrlr: expected writes come from a nested-loop
// reference of the convolution schedule; a negedge monitor pops and compares.
module tb_cnnip_seq_ctrlr;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int IMG_DIM = 16;
  localparam int MAX_K   = 5;
  localparam int MAX_NK  = 8;
  localparam int XA_W    = $clog2(IMG_DIM*IMG_DIM);
  localparam int WA_W    = $clog2(MAX_NK*MAX_K*MAX_K);
  localparam int FA_W    = $clog2(MAX_NK*IMG_DIM*IMG_DIM);
  localparam int NPIX    = IMG_DIM*IMG_DIM;

  logic clk_a = 1'b0, arstz_aq = 1'b0, cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [7:0] mode_kernel_size = '0, mode_kernel_nums = '0;
  logic [1:0] mode_stride = '0;
  logic mode_padding = 1'b0;
  logic x_valid = 1'b0, w_valid = 1'b0;
  logic [DATA_W-1:0] x_data = '0, w_data = '0;
  logic pe_done = 1'b0;
  logic [ACC_W-1:0] pe_result = '0;
  logic x_ready, w_ready, xmem_we, wmem_we, pe_start, fmem_we, busy, cmd_done, cmd_err;
  logic [XA_W-1:0] xmem_addr;
  logic [WA_W-1:0] wmem_addr;
  logic [FA_W-1:0] fmem_addr;
  logic [DATA_W-1:0] xmem_wdata, wmem_wdata;
  logic [ACC_W-1:0] fmem_wdata;
  logic [7:0] pe_kidx, pe_oy, pe_ox;

  cnnip_seq_ctrlr #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IMG_DIM(IMG_DIM), .MAX_K(MAX_K), .MAX_NK(MAX_NK)) dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .mode_kernel_size(mode_kernel_size), .mode_kernel_nums(mode_kernel_nums),
    .mode_stride(mode_stride), .mode_padding(mode_padding),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .xmem_we(xmem_we), .xmem_addr(xmem_addr), .xmem_wdata(xmem_wdata),
    .wmem_we(wmem_we), .wmem_addr(wmem_addr), .wmem_wdata(wmem_wdata),
    .pe_start(pe_start), .pe_kidx(pe_kidx), .pe_oy(pe_oy), .pe_ox(pe_ox),
    .pe_done(pe_done), .pe_result(pe_result),
    .fmem_we(fmem_we), .fmem_addr(fmem_addr), .fmem_wdata(fmem_wdata),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err));

  always #5 clk_a = ~clk_a;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int k; int oy; int ox; int addr; } crd_t;

  wr_t  xq[$], wq[$];
  crd_t cq[$];
  int   faq[$], fdq[$];
  bit   dq[$];

  int n_tests = 0, n_fail = 0;
  int xw_n = 0, ww_n = 0, fw_n = 0, ps_n = 0, done_n = 0;
  int xl = 0, wl = 0, fl = 0, lk = 0, loy = 0, lox = 0;
  int pe_dmin = 1, pe_dmax = 1;
  bit pe_noise = 1'b0, pe_poke = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs_nz();
    return int'(|{x_ready, w_ready, xmem_we, xmem_addr, xmem_wdata, wmem_we, wmem_addr, wmem_wdata,
                  pe_start, pe_kidx, pe_oy, pe_ox, fmem_we, fmem_addr, fmem_wdata, busy, cmd_done, cmd_err});
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_a); #1; end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, pe_start or cmd_done.
  initial begin
    wr_t e;
    crd_t c;
    forever begin
      @(negedge clk_a);
      if (!arstz_aq) begin
        xq.delete(); wq.delete(); cq.delete(); faq.delete(); fdq.delete(); dq.delete();
      end else begin
        if (xmem_we) begin
          xw_n++; xl = int'(xmem_addr);
          if (xq.size() == 0) chk("xmem_unexpected", longint'(xmem_addr), -1);
          else begin
            e = xq.pop_front();
            chk("xmem_addr", longint'(xmem_addr), e.addr);
            chk("xmem_data", longint'(xmem_wdata), e.data);
          end
        end
        if (wmem_we) begin
          ww_n++; wl = int'(wmem_addr);
          if (wq.size() == 0) chk("wmem_unexpected", longint'(wmem_addr), -1);
          else begin
            e = wq.pop_front();
            chk("wmem_addr", longint'(wmem_addr), e.addr);
            chk("wmem_data", longint'(wmem_wdata), e.data);
          end
        end
        if (pe_start) begin
          ps_n++; lk = int'(pe_kidx); loy = int'(pe_oy); lox = int'(pe_ox);
          if (cq.size() == 0) chk("pe_start_unexpected", longint'(pe_ox), -1);
          else begin
            c = cq.pop_front();
            chk("pe_coord", longint'(pe_kidx)*65536 + longint'(pe_oy)*256 + longint'(pe_ox),
                longint'(c.k)*65536 + longint'(c.oy)*256 + longint'(c.ox));
            faq.push_back(c.addr);
          end
        end
        if (fmem_we) begin
          fw_n++; fl = int'(fmem_addr);
          if (faq.size() == 0 || fdq.size() == 0) chk("fmem_unexpected", longint'(fmem_addr), -1);
          else begin
            chk("fmem_addr", longint'(fmem_addr), faq.pop_front());
            chk("fmem_data", longint'(fmem_wdata), fdq.pop_front());
          end
        end
        if (cmd_done) begin
          done_n++;
          if (dq.size() == 0) chk("cmd_done_unexpected", longint'(cmd_done), 0);
          else chk("cmd_err", longint'(cmd_err), longint'(dq.pop_front()));
        end
      end
    end
  end

  // PE model: answers each pe_start after a random latency with a random result.
  initial begin
    int cnt, val;
    cnt = 0; val = 0;
    forever begin
      @(negedge clk_a);
      if (arstz_aq && pe_start) begin
        cnt = int'($urandom_range(pe_dmax, pe_dmin));
        val = int'($urandom_range(0, (1 << ACC_W) - 1));
        fdq.push_back(val);
      end
      @(posedge clk_a); #1;
      if (!arstz_aq) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        pe_done = (cnt == 0);
        pe_result = (cnt == 0) ? val[ACC_W-1:0] : ACC_W'($urandom);
      end else begin
        pe_done = pe_poke || (pe_noise && ($urandom_range(0, 3) == 0));
        pe_result = ACC_W'($urandom);
      end
    end
  end

  task automatic drive_x(input int d[$], input int gap);
    int i, g;
    bit took;
    i = 0; g = 0;
    while (i < d.size() && g < 20000) begin
      x_valid = ($urandom_range(0, 99) >= gap);
      x_data = d[i][DATA_W-1:0];
      cmd_start = ($urandom_range(0, 3) == 0);
      @(negedge clk_a);
      took = x_valid && x_ready;
      @(posedge clk_a); #1;
      if (took) i++;
      g++;
    end
    x_valid = 1'b0; cmd_start = 1'b0;
    chk("x_beats", i, d.size());
  endtask

  task automatic drive_w(input int d[$], input int gap, input int abort_at);
    int i, g;
    bit took;
    i = 0; g = 0;
    while (i < d.size() && g < 20000) begin
      if (i == abort_at) begin
        w_valid = 1'b1; w_data = d[i][DATA_W-1:0]; cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0; w_valid = 1'b0;
        return;
      end
      w_valid = ($urandom_range(0, 99) >= gap);
      w_data = d[i][DATA_W-1:0];
      @(negedge clk_a);
      took = w_valid && w_ready;
      @(posedge clk_a); #1;
      if (took) i++;
      g++;
    end
    w_valid = 1'b0;
    chk("w_beats", i, d.size());
  endtask

  task automatic run_cfg(input int k, input int nk, input int s, input int pad, input int gap,
                         input int dmin, input int dmax, input int abort_at, input int rst_after);
    int p, o, x0, w0, f0, d0, cyc;
    bit bad;
    int xd[$], wd[$];
    p = pad ? (k - 1) / 2 : 0;
    bad = (k == 0) || (k > MAX_K) || (nk == 0) || (nk > MAX_NK) || (s == 0) || (k > IMG_DIM + 2*p);
    o = bad ? 0 : (IMG_DIM + 2*p - k) / s + 1;
    pe_dmin = dmin; pe_dmax = dmax;
    x0 = xw_n; w0 = ww_n; f0 = fw_n; d0 = done_n;
    if (abort_at < 0) dq.push_back(bad);
    if (!bad) begin
      for (int i = 0; i < NPIX; i++) begin
        xd.push_back(int'($urandom_range(0, 255)));
        xq.push_back('{i, xd[i]});
      end
      for (int i = 0; i < nk*k*k; i++) begin
        wd.push_back(int'($urandom_range(0, 255)));
        if (abort_at < 0 || i < abort_at) wq.push_back('{i, wd[i]});
      end
      if (abort_at < 0)
        for (int kk = 0; kk < nk; kk++)
          for (int yy = 0; yy < o; yy++)
            for (int xx = 0; xx < o; xx++)
              cq.push_back('{kk, yy, xx, kk*o*o + yy*o + xx});
    end
    mode_kernel_size = 8'(k); mode_kernel_nums = 8'(nk);
    mode_stride = 2'(s); mode_padding = pad[0];
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    mode_kernel_size = 8'($urandom); mode_kernel_nums = 8'($urandom);
    mode_stride = 2'($urandom); mode_padding = 1'($urandom);
    if (bad) begin
      @(negedge clk_a); #1;
      chk("illegal_done_latency", done_n - d0, 1);
      tick(2);
      chk("illegal_no_writes", (xw_n - x0) + (ww_n - w0) + (fw_n - f0), 0);
      chk("illegal_idle", longint'(busy), 0);
      return;
    end
    drive_x(xd, gap);
    drive_w(wd, gap, abort_at);
    if (abort_at >= 0) begin
      chk("abort_idle", longint'(busy), 0);
      tick(3);
      chk("abort_no_done", done_n - d0, 0);
      chk("abort_w_writes", ww_n - w0, abort_at);
      chk("abort_wq_left", wq.size(), 0);
      return;
    end
    if (rst_after >= 0) begin
      cyc = 0;
      while (fw_n - f0 < rst_after && cyc < 30000) begin tick(); cyc++; end
      chk("rst_reached_conv", (fw_n - f0 >= rst_after) ? 1 : 0, 1);
      #2 arstz_aq = 1'b0;
      #1 chk("rst_outputs_zero", outs_nz(), 0);
      tick(2);
      arstz_aq = 1'b1;
      tick();
      chk("rst_idle", longint'(busy), 0);
      f0 = fw_n; d0 = done_n;
      pe_poke = 1'b1;
      tick();
      pe_poke = 1'b0;
      tick(2);
      chk("idle_pe_done_no_write", fw_n - f0, 0);
      chk("rst_no_done", done_n - d0, 0);
      return;
    end
    cyc = 0;
    while (done_n == d0 && cyc < 30000) begin tick(); cyc++; end
    chk("cmd_done_count", done_n - d0, 1);
    chk("cq_drained", cq.size(), 0);
    chk("fq_drained", faq.size(), 0);
    chk("xq_drained", xq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    chk("x_writes", xw_n - x0, NPIX);
    chk("x_last_addr", xl, NPIX - 1);
    chk("w_writes", ww_n - w0, nk*k*k);
    chk("w_last_addr", wl, nk*k*k - 1);
    chk("f_writes", fw_n - f0, nk*o*o);
    chk("f_last_addr", fl, nk*o*o - 1);
    chk("idle_after_done", longint'(busy), 0);
  endtask

  initial begin
    int ps0;
    #1 chk("reset_outputs_zero", outs_nz(), 0);
    tick(2);
    arstz_aq = 1'b1;
    tick();
    chk("idle_after_reset", longint'(busy), 0);

    run_cfg(3, 2, 1, 0, 0, 1, 1, -1, -1);

    ps0 = ps_n;
    run_cfg(3, 1, 2, 1, 0, 1, 2, -1, -1);
    chk("t2_pe_starts", ps_n - ps0, 64);
    chk("t2_last_ox", lox, 7);
    chk("t2_last_oy", loy, 7);
    chk("t2_last_k", lk, 0);

    pe_noise = 1'b1;
    for (int r = 0; r < 3; r++)
      run_cfg(int'($urandom_range(1, MAX_K)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 1)), 40, 1, 5, -1, -1);

    run_cfg(0, 2, 1, 0, 0, 1, 1, -1, -1);
    run_cfg(3, 2, 0, 0, 0, 1, 1, -1, -1);
    run_cfg(3, 9, 1, 0, 0, 1, 1, -1, -1);
    run_cfg(6, 1, 1, 1, 0, 1, 1, -1, -1);

    run_cfg(3, 2, 1, 0, 20, 1, 2, 5, -1);
    run_cfg(2, 1, 3, 0, 20, 1, 3, -1, -1);

    run_cfg(3, 1, 1, 1, 20, 1, 3, -1, 40);
    run_cfg(1, 1, 1, 0, 10, 1, 2, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule
